// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first: serialises tx_data on MOSI, captures MISO into rx_data.
// Frame: CS falls on accept, DATA_W SCK pulses of 2*CLK_DIV cycles, then CS hold/gap phases.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic              CS,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bitcnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              div_tick;

  assign div_tick = (div == DIV_LAST);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bitcnt  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      MOSI    <= 1'b0;
      SCK     <= 1'b0;
      CS      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          CS     <= 1'b1;
          SCK    <= 1'b0;
          MOSI   <= 1'b0;
          div    <= '0;
          bitcnt <= '0;
          if (start) begin
            tx_sr <= tx_data;
            MOSI  <= tx_data[DATA_W-1];
            CS    <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (div_tick) begin
            div   <= '0;
            SCK   <= 1'b1;
            rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            state <= SHIFT;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT: begin
          if (div_tick) begin
            div <= '0;
            if (!SCK) begin
              SCK   <= 1'b1;
              rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            end else begin
              SCK <= 1'b0;
              if (bitcnt == BIT_LAST) begin
                state <= HOLD;
              end else begin
                // tx_sr keeps the bit on the wire at its MSB, so the next bit is one below
                bitcnt <= bitcnt + 1'b1;
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                MOSI   <= tx_sr[DATA_W-2];
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        HOLD: begin
          if (div_tick) begin
            div   <= '0;
            CS    <= 1'b1;
            MOSI  <= 1'b0;
            state <= GAP;
          end else begin
            div <= div + 1'b1;
          end
        end
        GAP: begin
          if (div_tick) begin
            div     <= '0;
            rx_data <= rx_sr;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (8-bit/div 4 and 4-bit/div 1) checked every cycle
// against a timing model derived from elapsed cycles since the accept edge.
module tb_spi_master;

  logic       sclk = 1'b0;
  logic [1:0] rstv = 2'b11;
  logic [1:0] startv = 2'b00;
  logic [7:0] txa = '0;
  logic [3:0] txb = '0;
  logic [1:0] lb = 2'b11;
  logic [1:0] mval = 2'b00;
  bit         mrand = 1'b0;
  bit         chk_en = 1'b0;

  logic       mosi_a, sck_a, cs_a, busy_a, done_a;
  logic       mosi_b, sck_b, cs_b, busy_b, done_b;
  logic [7:0] rx_a;
  logic [3:0] rx_b;
  logic [1:0] miso, mosiv, sckv, csv, busyv, donev;

  assign miso  = {lb[1] ? mosi_b : mval[1], lb[0] ? mosi_a : mval[0]};
  assign mosiv = {mosi_b, mosi_a};
  assign sckv  = {sck_b, sck_a};
  assign csv   = {cs_b, cs_a};
  assign busyv = {busy_b, busy_a};
  assign donev = {done_b, done_a};

  spi_master #(.DATA_W(8), .CLK_DIV(4)) dut_a (
    .sclk(sclk), .rst(rstv[0]), .start(startv[0]), .tx_data(txa), .MISO(miso[0]),
    .MOSI(mosi_a), .SCK(sck_a), .CS(cs_a), .busy(busy_a), .done(done_a), .rx_data(rx_a)
  );

  spi_master #(.DATA_W(4), .CLK_DIV(1)) dut_b (
    .sclk(sclk), .rst(rstv[1]), .start(startv[1]), .tx_data(txb), .MISO(miso[1]),
    .MOSI(mosi_b), .SCK(sck_b), .CS(cs_b), .busy(busy_b), .done(done_b), .rx_data(rx_b)
  );

  always #5 sclk = ~sclk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: frame state is just "active" plus elapsed cycles since accept.
  bit         mact[2];
  bit         medone[2];
  int         me[2];
  logic [7:0] mtx[2];
  logic [7:0] mrx[2];
  logic [7:0] merx[2];

  function automatic int pdw(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int pdv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(posedge sclk) begin
    for (int i = 0; i < 2; i++) begin
      int dw, dv;
      dw = pdw(i);
      dv = pdv(i);
      medone[i] = 1'b0;
      if (rstv[i]) begin
        mact[i] = 1'b0;
        merx[i] = '0;
      end else if (mact[i]) begin
        me[i]++;
        if ((me[i] % dv == 0) && ((me[i] / dv) % 2 == 1) && (me[i] / dv < 2 * dw))
          mrx[i] = {mrx[i][6:0], miso[i]};
        if (me[i] == (2 * dw + 2) * dv) begin
          mact[i]   = 1'b0;
          merx[i]   = mrx[i];
          medone[i] = 1'b1;
        end
      end else if (startv[i]) begin
        mact[i] = 1'b1;
        me[i]   = 0;
        mtx[i]  = (i == 0) ? txa : {4'b0, txb};
        mrx[i]  = '0;
      end
    end
  end

  function automatic logic [12:0] mexp(input int i);
    int dw, dv, e, q, h;
    logic c, s, m, b, d;
    dw = pdw(i);
    dv = pdv(i);
    if (mact[i]) begin
      e = me[i];
      q = e / dv;
      h = e / (2 * dv);
      if (h > dw - 1) h = dw - 1;
      c = (e >= (2 * dw + 1) * dv);
      s = (q % 2 == 1) && (q < 2 * dw);
      m = c ? 1'b0 : mtx[i][dw - 1 - h];
      b = 1'b1;
      d = 1'b0;
    end else begin
      c = 1'b1; s = 1'b0; m = 1'b0; b = 1'b0; d = medone[i];
    end
    return {c, s, m, b, d, merx[i]};
  endfunction

  always @(negedge sclk) begin
    if (chk_en) begin
      chk("cycle_outputs_a", {cs_a, sck_a, mosi_a, busy_a, done_a, rx_a}, mexp(0));
      chk("cycle_outputs_b", {cs_b, sck_b, mosi_b, busy_b, done_b, 4'b0, rx_b}, mexp(1));
    end
  end

  // Frame observations used by the hand-computed literal checks.
  int         cyc = 0;
  logic [1:0] pbusy = '0, psck = '0, pcs = '1;
  int         rises[2], cslow[2], ones[2], acc_cyc[2], done_cyc[2], ndone[2], cs_rise[2], gap[2];
  logic [7:0] mbits[2];

  always @(negedge sclk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (busyv[i] === 1'b1 && pbusy[i] !== 1'b1) begin
        acc_cyc[i] = cyc; rises[i] = 0; cslow[i] = 0; ones[i] = 0; mbits[i] = '0;
      end
      if (sckv[i] === 1'b1 && psck[i] !== 1'b1) begin
        rises[i]++;
        mbits[i] = {mbits[i][6:0], mosiv[i]};
      end
      if (csv[i] === 1'b0) cslow[i]++;
      if (mosiv[i] === 1'b1) ones[i]++;
      if (csv[i] === 1'b1 && pcs[i] === 1'b0) cs_rise[i] = cyc;
      if (csv[i] === 1'b0 && pcs[i] === 1'b1) gap[i] = cyc - cs_rise[i];
      if (donev[i] === 1'b1) begin done_cyc[i] = cyc; ndone[i]++; end
    end
    pbusy = busyv; psck = sckv; pcs = csv;
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; cslow[i] = 0; ones[i] = 0; acc_cyc[i] = 0;
      done_cyc[i] = 0; ndone[i] = 0; cs_rise[i] = 0; gap[i] = 0; mbits[i] = '0;
    end
  end

  initial begin
    forever begin
      @(negedge sclk);
      if (mrand) mval = 2'($urandom);
    end
  end

  task automatic tick();
    @(negedge sclk);
    #1;
  endtask

  task automatic pulse_start(input int i, input logic [7:0] tx);
    if (i == 0) txa = tx; else txb = tx[3:0];
    startv[i] = 1'b1;
    tick();
    startv[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (donev[i] !== 1'b1 && n < budget);
    chk("done_within_budget", donev[i], 1'b1);
  endtask

  initial begin
    int nd, d1;
    repeat (3) tick();
    rstv = 2'b00;
    chk_en = 1'b1;
    chk("reset_a", {cs_a, sck_a, mosi_a, busy_a, done_a, rx_a}, {5'b10000, 8'h00});
    chk("reset_b", {cs_b, sck_b, mosi_b, busy_b, done_b, rx_b}, {5'b10000, 4'h0});

    // Loopback 0xA5 with default parameters
    lb[0] = 1'b1;
    pulse_start(0, 8'hA5);
    wait_done(0, 200);
    chk("lb_a5_rx", rx_a, 8'hA5);
    chk("lb_a5_latency", done_cyc[0] - acc_cyc[0], 72);
    chk("lb_a5_sck_rises", rises[0], 8);
    chk("lb_a5_mosi_bits", mbits[0], 8'hA5);
    chk("lb_a5_cs_low", cslow[0], 68);

    // Tied MISO
    lb[0] = 1'b0; mval[0] = 1'b1;
    repeat (3) tick();
    pulse_start(0, 8'h00);
    wait_done(0, 200);
    chk("miso1_rx", rx_a, 8'hFF);
    chk("miso1_mosi_ones", ones[0], 0);
    mval[0] = 1'b0;
    repeat (3) tick();
    pulse_start(0, 8'hFF);
    wait_done(0, 200);
    chk("miso0_rx", rx_a, 8'h00);

    // Start pulse mid-frame must be ignored
    lb[0] = 1'b1;
    repeat (3) tick();
    nd = ndone[0];
    pulse_start(0, 8'hA5);
    repeat (19) tick();
    txa = 8'h3C; startv[0] = 1'b1;
    tick();
    startv[0] = 1'b0;
    wait_done(0, 200);
    repeat (10) tick();
    chk("ignored_start_ndone", ndone[0] - nd, 1);
    chk("ignored_start_rx", rx_a, 8'hA5);
    chk("ignored_start_idle", busy_a, 1'b0);

    // Reset mid-frame
    pulse_start(0, 8'hC3);
    repeat (29) tick();
    rstv[0] = 1'b1;
    tick();
    rstv[0] = 1'b0;
    chk("midrst_outputs", {cs_a, sck_a, mosi_a, busy_a, done_a, rx_a}, {5'b10000, 8'h00});
    nd = ndone[0];
    repeat (80) tick();
    chk("midrst_no_done", ndone[0] - nd, 0);
    pulse_start(0, 8'h5A);
    wait_done(0, 200);
    chk("after_rst_rx", rx_a, 8'h5A);

    // start held across two frames
    repeat (3) tick();
    txa = 8'h81; startv[0] = 1'b1;
    wait_done(0, 200);
    chk("held_first_rx", rx_a, 8'h81);
    d1 = done_cyc[0];
    txa = 8'h7E;
    tick();
    startv[0] = 1'b0;
    wait_done(0, 200);
    chk("held_second_rx", rx_a, 8'h7E);
    chk("held_accept_after_done", acc_cyc[0] - d1, 1);
    chk("held_cs_gap_ok", gap[0] >= 5, 1'b1);

    // CLK_DIV=1, DATA_W=4
    lb[1] = 1'b1;
    pulse_start(1, 8'h0B);
    wait_done(1, 50);
    chk("div1_rx", rx_b, 4'hB);
    chk("div1_latency", done_cyc[1] - acc_cyc[1], 10);
    chk("div1_sck_rises", rises[1], 4);
    chk("div1_mosi_bits", mbits[1][3:0], 4'hB);

    // Randomised traffic on both instances
    nd = ndone[0] + ndone[1];
    mrand = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 256 == 0) lb = 2'($urandom);
      txa = 8'($urandom);
      txb = 4'($urandom);
      for (int i = 0; i < 2; i++) begin
        startv[i] = ($urandom_range(0, 7) == 0);
        rstv[i]   = ($urandom_range(0, 299) == 0);
      end
      tick();
    end
    startv = '0;
    rstv = '0;
    repeat (200) tick();
    chk("random_frames_completed", (ndone[0] + ndone[1] - nd) > 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
